meas_result_calc: RTL and testbench

- Downstream consumer of the frequency/duty counter top.
- Takes one gate's raw counts (x_count, r_count, xh_count, xl_count, xy_count) and converts them to engineering units: frequency in Hz, duty in 0.1 %, and x-to-y phase in 0.1 degree.
- Uses one shared sequential restoring divider, time-multiplexed over three divisions.
- Results are registered for the readout/display stage.

---
 rtl/meas_result_calc_pkg.sv | 28 ++
 rtl/meas_result_calc_seq_divider.sv | 80 ++++++++
 rtl/meas_result_calc.sv | 156 +++++++++++++++
 tb/tb_meas_result_calc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/meas_result_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meas_result_calc_pkg
// Description : Shared constants and FSM state type for the measurement
//               result calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package meas_result_calc_pkg;

    localparam int F_REF_HZ_DEFAULT = 200_000_000;
    localparam int DUTY_SCALE       = 1000;
    localparam int PHASE_SCALE      = 3600;

    localparam int ST_FREQ_DZ  = 0;
    localparam int ST_DUTY_DZ  = 1;
    localparam int ST_PHASE_DZ = 2;
    localparam int ST_FREQ_SAT = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FREQ  = 3'd1,
        S_DUTY  = 3'd2,
        S_PHASE = 3'd3,
        S_DONE  = 3'd4
    } meas_state_e;

endpackage
`default_nettype wire

// File: rtl/meas_result_calc_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring divider, one quotient bit per cycle, fixed latency
//               of DIVIDEND_W+2 cycles including the divide-by-zero case.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient,
    output logic                  o_div_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic                  r_active;
    logic                  r_cap;
    logic                  r_dz;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_q;

    logic [DIVISOR_W:0]    w_rem_sh;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;

    // Dividend bits shift out of r_q's top while quotient bits enter at the bottom.
    assign w_rem_sh = {r_rem, r_q[DIVIDEND_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    assign w_diff   = w_rem_sh[DIVISOR_W-1:0] - r_divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_cap     <= 1'b0;
            r_dz      <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_q       <= '0;
        end else if (r_cap) begin
            r_cap <= 1'b0;
        end else if (r_active) begin
            // A zero divisor still walks the counter so latency is unchanged.
            if (!r_dz) begin
                r_rem <= w_ge ? w_diff : w_rem_sh[DIVISOR_W-1:0];
                r_q   <= {r_q[DIVIDEND_W-2:0], w_ge};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(DIVIDEND_W - 1)) begin
                r_active <= 1'b0;
                r_cap    <= 1'b1;
            end
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_dz      <= (i_divisor == '0);
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_q       <= i_dividend;
        end
    end

    assign o_busy     = r_active | r_cap;
    assign o_done     = r_cap;
    assign o_quotient = r_dz ? '0 : r_q;
    assign o_div_zero = r_dz;

endmodule
`default_nettype wire

// File: rtl/meas_result_calc.sv
`default_nettype none
// ============================================================================
// Module      : meas_result_calc
// Description : Converts gate counts to frequency, duty and phase using one
//               time-multiplexed sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
module meas_result_calc
    import meas_result_calc_pkg::*;
#(
    parameter int F_REF = F_REF_HZ_DEFAULT,
    parameter int CW    = 32,
    parameter int DIV_W = 64
) (
    input  logic          clk200M,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [CW-1:0] x_count,
    input  logic [CW-1:0] r_count,
    input  logic [CW-1:0] xh_count,
    input  logic [CW-1:0] xl_count,
    input  logic [CW-1:0] xy_count,
    output logic          busy,
    output logic          out_valid,
    output logic [31:0]   freq_hz,
    output logic [9:0]    duty_pm,
    output logic [11:0]   phase_dx10,
    output logic [3:0]    status
);

    meas_state_e r_state, w_next;

    logic [CW-1:0]    r_x, r_r, r_xh, r_xl, r_xy;
    logic             r_busy, r_out_valid;
    logic [31:0]      r_freq_res, r_freq;
    logic [9:0]       r_duty_res, r_duty;
    logic [11:0]      r_phase_res, r_phase;
    logic [3:0]       r_st_res, r_status;

    logic [CW:0]      w_sum;
    logic [DIV_W-1:0] w_dividend;
    logic [CW:0]      w_divisor;
    logic             w_start, w_div_busy, w_div_done, w_div_zero;
    logic [DIV_W-1:0] w_quot;

    assign w_sum = {1'b0, r_xh} + {1'b0, r_xl};

    always_comb begin
        w_dividend = '0;
        w_divisor  = w_sum;
        case (r_state)
            S_FREQ: begin
                w_dividend = DIV_W'(r_x) * DIV_W'(F_REF);
                w_divisor  = {1'b0, r_r};
            end
            S_DUTY:  w_dividend = DIV_W'(r_xh) * DIV_W'(DUTY_SCALE);
            S_PHASE: w_dividend = DIV_W'(r_xy) * DIV_W'(PHASE_SCALE);
            default: ;
        endcase
    end

    // The divider's busy flag doubles as the "already launched" marker per state.
    assign w_start = (r_state inside {S_FREQ, S_DUTY, S_PHASE}) && !w_div_busy;

    seq_divider #(
        .DIVIDEND_W (DIV_W),
        .DIVISOR_W  (CW + 1)
    ) u_div (
        .clk        (clk200M),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot),
        .o_div_zero (w_div_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)   w_next = S_FREQ;
            S_FREQ:  if (w_div_done) w_next = S_DUTY;
            S_DUTY:  if (w_div_done) w_next = S_PHASE;
            S_PHASE: if (w_div_done) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk200M) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_r         <= '0;
            r_xh        <= '0;
            r_xl        <= '0;
            r_xy        <= '0;
            r_freq_res  <= '0;
            r_duty_res  <= '0;
            r_phase_res <= '0;
            r_st_res    <= '0;
            r_freq      <= '0;
            r_duty      <= '0;
            r_phase     <= '0;
            r_status    <= '0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != S_IDLE);
            r_out_valid <= (r_state == S_DONE);
            if (r_state == S_IDLE && in_valid) begin
                r_x  <= x_count;
                r_r  <= r_count;
                r_xh <= xh_count;
                r_xl <= xl_count;
                r_xy <= xy_count;
            end
            if (w_div_done) begin
                case (r_state)
                    S_FREQ: begin
                        r_st_res[ST_FREQ_DZ]  <= w_div_zero;
                        r_st_res[ST_FREQ_SAT] <= |w_quot[DIV_W-1:32];
                        r_freq_res <= (|w_quot[DIV_W-1:32]) ? 32'hFFFF_FFFF : w_quot[31:0];
                    end
                    S_DUTY: begin
                        r_st_res[ST_DUTY_DZ] <= w_div_zero;
                        r_duty_res <= (w_quot > DIV_W'(DUTY_SCALE)) ? 10'(DUTY_SCALE) : w_quot[9:0];
                    end
                    S_PHASE: begin
                        r_st_res[ST_PHASE_DZ] <= w_div_zero;
                        r_phase_res <= (w_quot > DIV_W'(PHASE_SCALE)) ? 12'(PHASE_SCALE) : w_quot[11:0];
                    end
                    default: ;
                endcase
            end
            if (r_state == S_DONE) begin
                r_freq   <= r_freq_res;
                r_duty   <= r_duty_res;
                r_phase  <= r_phase_res;
                r_status <= r_st_res;
            end
        end
    end

    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign freq_hz    = r_freq;
    assign duty_pm    = r_duty;
    assign phase_dx10 = r_phase;
    assign status     = r_status;

endmodule
`default_nettype wire

// File: tb/tb_meas_result_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_meas_result_calc
// Description : Directed scoreboard bench for meas_result_calc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meas_result_calc;

    logic        clk200M = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] x_count = '0, r_count = '0, xh_count = '0, xl_count = '0, xy_count = '0;
    logic        busy, out_valid;
    logic [31:0] freq_hz;
    logic [9:0]  duty_pm;
    logic [11:0] phase_dx10;
    logic [3:0]  status;

    typedef struct {
        logic [31:0] f;
        logic [9:0]  d;
        logic [11:0] p;
        logic [3:0]  s;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    meas_result_calc dut (
        .clk200M    (clk200M),
        .rst        (rst),
        .in_valid   (in_valid),
        .x_count    (x_count),
        .r_count    (r_count),
        .xh_count   (xh_count),
        .xl_count   (xl_count),
        .xy_count   (xy_count),
        .busy       (busy),
        .out_valid  (out_valid),
        .freq_hz    (freq_hz),
        .duty_pm    (duty_pm),
        .phase_dx10 (phase_dx10),
        .status     (status)
    );

    always #5 clk200M = ~clk200M;
    always @(posedge clk200M) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, r, xh, xl, xy);
        exp_t        e;
        logic [63:0] q, sum;
        e.s = 4'b0000;
        e.acc = 0;
        if (r == 0) begin
            e.f = 32'd0;
            e.s[0] = 1'b1;
        end else begin
            q = (64'(x) * 64'd200_000_000) / 64'(r);
            if (q > 64'hFFFF_FFFF) begin
                e.f = 32'hFFFF_FFFF;
                e.s[3] = 1'b1;
            end else e.f = q[31:0];
        end
        sum = 64'(xh) + 64'(xl);
        if (sum == 0) begin
            e.d = 10'd0;
            e.p = 12'd0;
            e.s[1] = 1'b1;
            e.s[2] = 1'b1;
        end else begin
            q = (64'(xh) * 64'd1000) / sum;
            e.d = (q > 64'd1000) ? 10'd1000 : q[9:0];
            q = (64'(xy) * 64'd3600) / sum;
            e.p = (q > 64'd3600) ? 12'd3600 : q[11:0];
        end
        return e;
    endfunction

    // Result checker: every out_valid must match the oldest pending expectation.
    always @(negedge clk200M) begin
        if (!rst && out_valid) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_out_valid observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("freq_hz", 64'(freq_hz), 64'(e.f));
                chk("duty_pm", 64'(duty_pm), 64'(e.d));
                chk("phase_dx10", 64'(phase_dx10), 64'(e.p));
                chk("status", 64'(status), 64'(e.s));
                chk("latency", 64'(cyc - e.acc), 64'd199);
            end
        end
    end

    task automatic launch(input logic [31:0] x, r, xh, xl, xy);
        exp_t e;
        x_count = x; r_count = r; xh_count = xh; xl_count = xl; xy_count = xy;
        in_valid = 1'b1;
        e = model(x, r, xh, xl, xy);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk200M);
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 260 && sb.size() != 0; i++) @(negedge clk200M);
        chk("result_timeout", 64'(sb.size()), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input logic [31:0] x, r, xh, xl, xy);
        launch(x, r, xh, xl, xy);
        drain();
    endtask

    initial begin
        repeat (3) @(negedge clk200M);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_freq", 64'(freq_hz), 64'd0);
        chk("rst_duty", 64'(duty_pm), 64'd0);
        chk("rst_phase", 64'(phase_dx10), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        @(negedge clk200M);

        run_vec(32'd10_000, 32'd200_000_000, 32'd5_000, 32'd15_000, 32'd5_000);
        repeat (10) @(negedge clk200M);
        chk("hold_freq", 64'(freq_hz), 64'd10_000);
        chk("hold_duty", 64'(duty_pm), 64'd250);
        chk("hold_phase", 64'(phase_dx10), 64'd900);

        run_vec(32'd10_000, 32'd0, 32'd0, 32'd0, 32'd5_000);
        run_vec(32'hFFFF_FFFF, 32'd1, 32'd5_000, 32'd15_000, 32'd5_000);
        run_vec(32'd10_000, 32'd200_000_000, 32'd5_000, 32'd15_000, 32'd30_000);
        run_vec(32'd1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7);

        // Second in_valid mid-calculation must be ignored.
        launch(32'd12_345, 32'd1_000_000, 32'd1, 32'd3, 32'd2);
        repeat (48) @(negedge clk200M);
        x_count = 32'd999; r_count = 32'd7; xh_count = 32'd9; xl_count = 32'd1; xy_count = 32'd5;
        in_valid = 1'b1;
        @(negedge clk200M);
        in_valid = 1'b0;
        drain();
        repeat (250) @(negedge clk200M);

        // Reset at cycle 100 aborts the calculation without an out_valid.
        launch(32'd777, 32'd123_456, 32'd40, 32'd60, 32'd10);
        repeat (99) @(negedge clk200M);
        rst = 1'b1;
        @(negedge clk200M);
        sb.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_freq", 64'(freq_hz), 64'd0);
        chk("abort_duty", 64'(duty_pm), 64'd0);
        chk("abort_phase", 64'(phase_dx10), 64'd0);
        chk("abort_status", 64'(status), 64'd0);
        rst = 1'b0;
        repeat (250) @(negedge clk200M);
        run_vec(32'd50_000, 32'd199_999_999, 32'd3, 32'd1, 32'd2);

        for (int k = 0; k < 4; k++) begin
            run_vec($urandom, $urandom_range(1, 32'hFFFF_FFFF), $urandom, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
